// File: rtl/totp_digit_sequencer.sv
// -----------------------------------------------------------------------------
// totp_digit_sequencer
//
// Purpose
//   Sits downstream of the TOTP code generator. Takes one packed BCD code per
//   valid/ready transfer and plays it out on a single 7-segment display, most
//   significant digit first. Each digit is shown for DWELL cycles and then the
//   display is blanked for GAP cycles (GAP == 0 removes the blank state).
//
// Parameters
//   NUM_DIGITS  digits per code, 1..8
//   DWELL       cycles each digit is shown, >= 1
//   GAP         blank cycles after each digit, 0 = no blank state
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active-low
//   code_bcd    packed BCD code, digit 0 (MSD) in the top nibble
//   code_valid  code_bcd carries a code this cycle
//   code_ready  block accepts a code this cycle
//   segments    7-segment drive ({g,f,e,d,c,b,a}, active high), 0 when blank
//   dp          high while digit 0 is shown (start-of-code marker)
//   digit_idx   index of the digit currently shown or just shown
//   busy        high whenever the sequencer is not idle
//   bad_digit   one-cycle pulse on the first shown cycle of a digit > 9
//
// Handshake
//   A code is transferred on a rising edge where code_valid && code_ready.
//   The code is copied into an internal register at that edge and code_bcd is
//   not looked at again. code_valid while code_ready is low is simply ignored.
//
// Build option
//   SEQ_REPEAT_EN  when defined, the latched code loops forever, code_ready is
//                  always high and any transfer restarts from digit 0.
//
// The FSM state register is state_q (type state_t) for hierarchical probing.
// -----------------------------------------------------------------------------

module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] segments
);
    // Segment order {g,f,e,d,c,b,a}; values above 9 decode to blank.
    always_comb begin
        segments = 7'h00;
        case (digit)
            4'd0: segments = 7'h3F;
            4'd1: segments = 7'h06;
            4'd2: segments = 7'h5B;
            4'd3: segments = 7'h4F;
            4'd4: segments = 7'h66;
            4'd5: segments = 7'h6D;
            4'd6: segments = 7'h7D;
            4'd7: segments = 7'h07;
            4'd8: segments = 7'h7F;
            4'd9: segments = 7'h6F;
            default: segments = 7'h00;
        endcase
    end
endmodule

module totp_digit_sequencer #(
    parameter int NUM_DIGITS = 6,
    parameter int DWELL      = 1000,
    parameter int GAP        = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] code_bcd,
    input  logic                    code_valid,
    output logic                    code_ready,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [2:0]              digit_idx,
    output logic                    busy,
    output logic                    bad_digit
);
    localparam int MAX_T = (DWELL > GAP) ? DWELL : GAP;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam int CW    = 4 * NUM_DIGITS;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   code_q, code_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic            accept;
    logic            end_digit;
    logic [3:0]      cur_digit;
    logic [6:0]      seg_raw;

`ifdef SEQ_REPEAT_EN
    assign code_ready = 1'b1;
`else
    assign code_ready = (state_q == S_IDLE);
`endif

    assign accept = code_valid && code_ready;

    // Select the nibble for the current index; digit 0 is the top nibble.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_digit = code_q[4*(NUM_DIGITS-1-i) +: 4];
            end
        end
    end

    seg7 u_seg7 (
        .digit    (cur_digit),
        .segments (seg_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            timer_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        end_digit = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (accept) begin
                    code_d  = code_bcd;
                    idx_d   = '0;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (timer_q == DWELL_LAST) begin
                    timer_d = '0;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                    end else begin
                        end_digit = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d   = '0;
                    end_digit = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        // Shared end-of-digit step, reached from SHOW (GAP == 0) or GAP.
        if (end_digit) begin
            if (idx_q == LAST_IDX) begin
`ifdef SEQ_REPEAT_EN
                idx_d   = '0;
                state_d = S_SHOW;
`else
                state_d = S_IDLE;
`endif
            end else begin
                idx_d   = idx_q + 3'd1;
                state_d = S_SHOW;
            end
        end

`ifdef SEQ_REPEAT_EN
        // A new code always wins, including on the end-of-code cycle.
        if (accept) begin
            code_d  = code_bcd;
            idx_d   = '0;
            timer_d = '0;
            state_d = S_SHOW;
        end
`endif
    end

    assign segments  = (state_q == S_SHOW) ? seg_raw : 7'h00;
    assign dp        = (state_q == S_SHOW) && (idx_q == 3'd0);
    assign digit_idx = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign bad_digit = (state_q == S_SHOW) && (timer_q == '0) && (cur_digit > 4'd9);

endmodule
